alarm_time_setter: RTL

//  Writer side of the alarm-time registers: produces the BCD ahour/amin pair

---
 rtl/alarm_pkg.sv | 22 ++
 rtl/bcd_inc_wrap.sv | 23 ++
 rtl/alarm_time_setter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/alarm_pkg.sv
// Shared types and limits for the alarm-time setter.
package alarm_pkg;

  // Button-handling FSM states
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRESS  = 2'd1,
    REPEAT = 2'd2,
    LOCK   = 2'd3
  } state_t;

  // Which time field a press/hold is acting on
  typedef enum logic {
    FIELD_HOUR = 1'b0,
    FIELD_MIN  = 1'b1
  } field_t;

  // Largest legal BCD values before wrapping back to 00
  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] MIN_MAX  = 8'h59;

endpackage

// File: rtl/bcd_inc_wrap.sv
// Combinational two-digit BCD increment that wraps to 00 once MAX is reached.
// Any input at or above MAX (including out-of-range values) maps to 00, so the
// result is always a legal BCD value in 00..MAX.
module bcd_inc_wrap #(
  parameter logic [7:0] MAX = 8'h59
) (
  input  logic [7:0] val,
  output logic [7:0] inc
);

  // Add one to the low digit, carrying into the high digit on 9 -> 0
  always_comb begin
    inc = 8'h00;
    if (val < MAX) begin
      if (val[3:0] >= 4'd9) begin
        inc = {val[7:4] + 4'd1, 4'h0};
      end else begin
        inc = {val[7:4], val[3:0] + 4'd1};
      end
    end
  end

endmodule

// File: rtl/alarm_time_setter.sv
// Alarm-time writer: synchronises raw buttons, detects rising edges, handles
// press / hold-to-repeat / two-button clear, and keeps the BCD alarm hour,
// minute and enable registers.
module alarm_time_setter
  import alarm_pkg::*;
#(
  parameter int         HOLD_CYCLES   = 500,
  parameter int         REPEAT_CYCLES = 100,
  parameter logic [7:0] RST_HOUR      = 8'h07,
  parameter logic [7:0] RST_MIN       = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       set_mode,
  input  logic       btn_hour,
  input  logic       btn_min,
  input  logic       btn_en,
  output logic [7:0] ahour,
  output logic [7:0] amin,
  output logic       alarm_en,
  output logic       changed
);

  localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT     = CNT_W'(CNT_MAX);

  // Button vectors are ordered {en, min, hour}
  logic [2:0] sync1, sync2, prev;
  logic [2:0] rise;
  logic       sh, sm;

  state_t           state, next_state;
  field_t           field, next_field;
  logic [CNT_W-1:0] cnt, next_cnt, last;
  logic [7:0]       next_hour, next_min;
  logic             next_changed;
  logic [7:0]       hour_inc, min_inc;
  logic             held, other_rise;

  bcd_inc_wrap #(.MAX(HOUR_MAX)) u_hour_inc (.val(ahour), .inc(hour_inc));
  bcd_inc_wrap #(.MAX(MIN_MAX))  u_min_inc  (.val(amin),  .inc(min_inc));

  // Two-flop synchroniser followed by a one-flop edge-detect history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      prev  <= '0;
    end else begin
      sync1 <= {btn_en, btn_min, btn_hour};
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign rise = sync2 & ~prev;
  assign sh   = sync2[0];
  assign sm   = sync2[1];

  // Enable flag toggles on every synced btn_en edge regardless of mode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alarm_en <= 1'b0;
    end else if (rise[2]) begin
      alarm_en <= ~alarm_en;
    end
  end

  // FSM state, hold counter and time registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      field   <= FIELD_HOUR;
      cnt     <= '0;
      ahour   <= RST_HOUR;
      amin    <= RST_MIN;
      changed <= 1'b0;
    end else begin
      state   <= next_state;
      field   <= next_field;
      cnt     <= next_cnt;
      ahour   <= next_hour;
      amin    <= next_min;
      changed <= next_changed;
    end
  end

  // Next-state logic: first press increments, long hold auto-repeats,
  // pressing the other button clears to 00:00 and locks until both release
  always_comb begin
    next_state   = state;
    next_field   = field;
    next_cnt     = cnt;
    next_hour    = ahour;
    next_min     = amin;
    next_changed = 1'b0;
    held         = (field == FIELD_HOUR) ? sh : sm;
    other_rise   = (field == FIELD_HOUR) ? rise[1] : rise[0];
    last         = (state == PRESS) ? HOLD_LAST : REPEAT_LAST;

    case (state)
      IDLE: begin
        if (set_mode) begin
          if (rise[0] && rise[1]) begin
            next_hour    = 8'h00;
            next_min     = 8'h00;
            next_changed = 1'b1;
            next_state   = LOCK;
          end else if (rise[0]) begin
            next_hour    = hour_inc;
            next_changed = 1'b1;
            next_field   = FIELD_HOUR;
            next_cnt     = '0;
            next_state   = PRESS;
          end else if (rise[1]) begin
            next_min     = min_inc;
            next_changed = 1'b1;
            next_field   = FIELD_MIN;
            next_cnt     = '0;
            next_state   = PRESS;
          end
        end
      end

      PRESS, REPEAT: begin
        if (!set_mode) begin
          next_cnt   = '0;
          next_state = IDLE;
        end else if (other_rise) begin
          next_hour    = 8'h00;
          next_min     = 8'h00;
          next_changed = 1'b1;
          next_cnt     = '0;
          next_state   = LOCK;
        end else if (!held) begin
          next_cnt   = '0;
          next_state = IDLE;
        end else if (cnt >= last) begin
          if (field == FIELD_HOUR) begin
            next_hour = hour_inc;
          end else begin
            next_min = min_inc;
          end
          next_changed = 1'b1;
          next_cnt     = '0;
          next_state   = REPEAT;
        end else if (cnt != CNT_SAT) begin
          next_cnt = cnt + 1'b1;
        end
      end

      LOCK: begin
        if (!set_mode || (!sh && !sm)) begin
          next_state = IDLE;
        end
      end

      default: begin
        next_cnt   = '0;
        next_state = IDLE;
      end
    endcase
  end

endmodule
